// File: rtl/pipe_pkg.sv
// Shared definitions for the 16/32-bit sequence-RAM pipe blocks.
// Holds FSM state encodings, the half-word select constants and the
// default address and word-count widths.
package pipe_pkg;

  localparam int AW = 16;  // RAM address width
  localparam int LW = 16;  // 32-bit word-count width

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Which half of a 32-bit word is on the 16-bit side.
  localparam logic S_L16 = 1'b0;
  localparam logic S_H16 = 1'b1;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Bundle of the ram_stream_reader control, RAM read port and 16-bit
// stream signals.
//   master : the reader (drives rd_en_o/addr_o/data16_o/valid_o/busy_o/done_o)
//   slave  : the environment (drives start/saddr/len, RAM data and ready)
interface ram_stream_reader_if #(
  parameter int AW = pipe_pkg::AW,
  parameter int LW = pipe_pkg::LW
);
  logic          start_i;
  logic [AW-1:0] saddr_i;
  logic [LW-1:0] len_i;
  logic          rd_en_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   data32_i;
  logic [15:0]   data16_o;
  logic          valid_o;
  logic          ready_i;
  logic          busy_o;
  logic          done_o;

  modport master (
    input  start_i, saddr_i, len_i, data32_i, ready_i,
    output rd_en_o, addr_o, data16_o, valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, saddr_i, len_i, data32_i, ready_i,
    input  rd_en_o, addr_o, data16_o, valid_o, busy_o, done_o
  );
endinterface

// File: rtl/fifo2_w32.sv
// Two-entry synchronous 32-bit FIFO used as the read prefetch buffer.
// Ports: clk_i, rst_n_i (sync, active-low), push_i/wdata_i write side,
// pop_i read side, head_o (oldest entry), empty_o, count_o (0..2).
// The caller guarantees no push when full and no pop when empty.
module fifo2_w32 (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  logic [31:0] wdata_i,
  input  logic        pop_i,
  output logic [31:0] head_o,
  output logic        empty_o,
  output logic [1:0]  count_o
);
  import pipe_pkg::*;

  logic [31:0] mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_i;
    rd_ptr_d = rd_ptr_q ^ pop_i;
    count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only observed when count_q > 0.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
endmodule

// File: rtl/ram_stream_reader.sv
// Reads len 32-bit words from the sequence RAM starting at saddr and
// streams them as 16-bit halves (low half first) over valid/ready.
// Ports: clk_i, rst_n_i (sync, active-low), bus (master modport):
//   start_i/saddr_i/len_i launch, rd_en_o/addr_o/data32_i RAM port
//   (1-cycle read latency), data16_o/valid_o/ready_i stream,
//   busy_o transfer in progress, done_o one-cycle completion pulse.
module ram_stream_reader #(
  parameter int AW = pipe_pkg::AW,
  parameter int LW = pipe_pkg::LW
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  ram_stream_reader_if.master bus
);
  import pipe_pkg::*;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] reads_left_q, reads_left_d;
  logic [LW-1:0] words_left_q, words_left_d;
  logic          inflight_q, inflight_d;
  logic          half_q, half_d;
  logic          done_q, done_d;

  logic          rd_en;
  logic          accept;
  logic          pop;
  logic [31:0]   head;
  logic          empty;
  logic [1:0]    count;

  // Returning RAM data is pushed only when this block issued the read in
  // the previous cycle; clearing inflight_q on reset drops stale returns.
  fifo2_w32 u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (inflight_q),
    .wdata_i (bus.data32_i),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (empty),
    .count_o (count)
  );

  // In-flight reads count toward the two-slot limit so a returning word
  // always has room in the buffer.
  assign rd_en  = (state_q == S_RUN) && (reads_left_q != '0) &&
                  (({1'b0, count} + {2'b00, inflight_q}) < 3'd2);
  assign accept = !empty && bus.ready_i;
  assign pop    = accept && (half_q == S_H16);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    reads_left_d = reads_left_q;
    words_left_d = words_left_q;
    inflight_d   = rd_en;
    half_d       = half_q;
    done_d       = 1'b0;

    if (rd_en) begin
      addr_d       = addr_q + AW'(1);
      reads_left_d = reads_left_q - LW'(1);
    end
    if (accept) half_d = (half_q == S_L16) ? S_H16 : S_L16;
    if (pop)    words_left_d = words_left_q - LW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i != '0) begin
            state_d      = S_RUN;
            addr_d       = bus.saddr_i;
            reads_left_d = bus.len_i;
            words_left_d = bus.len_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (rd_en && (reads_left_q == LW'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && (words_left_q == LW'(1))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      reads_left_q <= '0;
      words_left_q <= '0;
      inflight_q   <= 1'b0;
      half_q       <= S_L16;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      reads_left_q <= reads_left_d;
      words_left_q <= words_left_d;
      inflight_q   <= inflight_d;
      half_q       <= half_d;
      done_q       <= done_d;
    end
  end

  assign bus.rd_en_o  = rd_en;
  assign bus.addr_o   = addr_q;
  assign bus.valid_o  = !empty;
  assign bus.data16_o = empty ? 16'h0000 :
                        ((half_q == S_H16) ? head[31:16] : head[15:0]);
  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.done_o   = done_q;
endmodule
